io_ctl: RTL



---
 rtl/io_ctl_defs.sv | 31 +++
 rtl/kb_fifo.sv | 55 +++++
 rtl/io_ctl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/io_ctl_defs.sv
// Shared definitions for the LCR580 I/O and interrupt controller:
// port numbers, RST vectors, status bit positions and interrupt FSM states.
package io_ctl_defs;

   localparam logic [7:0] PORT_KB_DATA = 8'h00;
   localparam logic [7:0] PORT_STATUS  = 8'h01;
   localparam logic [7:0] PORT_VBL_CLR = 8'h02;
   localparam logic [7:0] PORT_FRAME   = 8'h03;
   localparam logic [7:0] PORT_BORDER  = 8'hFE;

   localparam logic [7:0] PORT_UNMAPPED = 8'hFF;

   localparam logic [7:0] VEC_VBLANK = 8'hD7;  // RST 2
   localparam logic [7:0] VEC_KB     = 8'hDF;  // RST 3
   localparam logic [7:0] VEC_NONE   = 8'hFF;

   localparam int STAT_NONEMPTY = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVERFLOW = 2;
   localparam int STAT_VBLANK   = 3;

   localparam int MASK_KB  = 0;
   localparam int MASK_VBL = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/kb_fifo.sv
// Keystroke FIFO. DEPTH must be a power of two; pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module kb_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          full, empty, pop_ok, push_ok;

   // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      count   = wr_ptr_q - rd_ptr_q;
      // A pop frees the head slot at the same edge, so a full FIFO can still accept a push.
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
   end

   assign head = mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/io_ctl.sv
// LCR580 port decoder, keyboard FIFO front end, border/mask registers,
// frame counter and fixed-priority RST interrupt sequencer.
module io_ctl
   import io_ctl_defs::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] port_a,
   input  logic [7:0] port_d,
   input  logic       port_we,
   input  logic       port_rd,
   output logic [7:0] port_in,
   input  logic       iff1,
   output logic       irq,
   input  logic       irq_ack,
   output logic [7:0] irq_vec,
   input  logic [7:0] kb_data,
   input  logic       kb_done,
   input  logic       vsync,
   output logic [2:0] border
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   irq_state_e state_q, state_d;
   logic       irq_q, irq_d;
   logic [7:0] irq_vec_q, irq_vec_d;
   logic [2:0] border_q, border_d;
   logic [1:0] mask_q, mask_d;
   logic       ovf_q, ovf_d;
   logic       vbl_q, vbl_d;
   logic [7:0] frame_q, frame_d;
   logic       vsync_q, vsync_d;

   logic [7:0]    kb_head;
   logic [CW-1:0] kb_count;
   logic          kb_empty, kb_full, kb_pop_req, kb_pop_ok;
   logic          vbl_edge, vbl_clr_wr, vbl_ack;
   logic          unused_port_d;

   assign unused_port_d = ^port_d[7:3];

   assign kb_empty   = (kb_count == '0);
   assign kb_full    = (kb_count == FULL_COUNT);
   assign kb_pop_req = port_rd && (port_a == PORT_KB_DATA);
   assign kb_pop_ok  = kb_pop_req && !kb_empty;

   kb_fifo #(.DEPTH(FIFO_DEPTH)) u_kb_fifo (
      .clock (clock),
      .reset (reset),
      .push  (kb_done),
      .pop   (kb_pop_req),
      .din   (kb_data),
      .head  (kb_head),
      .count (kb_count)
   );

   assign vbl_edge   = vsync & ~vsync_q;
   assign vbl_clr_wr = port_we && (port_a == PORT_VBL_CLR) && port_d[1];

   always_comb begin
      border_d = border_q;
      mask_d   = mask_q;
      ovf_d    = ovf_q;
      vbl_d    = vbl_q;
      frame_d  = frame_q + {7'd0, vbl_edge};
      vsync_d  = vsync;

      if (port_we && (port_a == PORT_BORDER)) border_d = port_d[2:0];
      if (port_we && (port_a == PORT_STATUS)) mask_d = port_d[1:0];

      // Setting events take precedence over clears landing in the same cycle.
      if (port_rd && (port_a == PORT_STATUS)) ovf_d = 1'b0;
      if (kb_done && kb_full && !kb_pop_ok)   ovf_d = 1'b1;

      if (vbl_clr_wr || vbl_ack) vbl_d = 1'b0;
      if (vbl_edge)              vbl_d = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      irq_d     = irq_q;
      irq_vec_d = irq_vec_q;
      vbl_ack   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iff1 && mask_q[MASK_VBL] && vbl_q) begin
               state_d   = ST_REQ;
               irq_d     = 1'b1;
               irq_vec_d = VEC_VBLANK;
            end else if (iff1 && mask_q[MASK_KB] && !kb_empty) begin
               state_d   = ST_REQ;
               irq_d     = 1'b1;
               irq_vec_d = VEC_KB;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               state_d = ST_SERVICE;
               irq_d   = 1'b0;
               vbl_ack = (irq_vec_q == VEC_VBLANK);
            end else if (!iff1) begin
               state_d = ST_IDLE;
               irq_d   = 1'b0;
            end
         end
         ST_SERVICE: begin
            if (iff1) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         irq_q     <= 1'b0;
         irq_vec_q <= VEC_NONE;
         border_q  <= '0;
         mask_q    <= '0;
         ovf_q     <= 1'b0;
         vbl_q     <= 1'b0;
         frame_q   <= '0;
         vsync_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_d;
         irq_vec_q <= irq_vec_d;
         border_q  <= border_d;
         mask_q    <= mask_d;
         ovf_q     <= ovf_d;
         vbl_q     <= vbl_d;
         frame_q   <= frame_d;
         vsync_q   <= vsync_d;
      end
   end

   always_comb begin
      port_in = PORT_UNMAPPED;
      case (port_a)
         PORT_KB_DATA: port_in = kb_empty ? 8'h00 : kb_head;
         PORT_STATUS: begin
            port_in                = 8'h00;
            port_in[STAT_NONEMPTY] = !kb_empty;
            port_in[STAT_FULL]     = kb_full;
            port_in[STAT_OVERFLOW] = ovf_q;
            port_in[STAT_VBLANK]   = vbl_q;
         end
         PORT_FRAME:  port_in = frame_q;
         PORT_BORDER: port_in = {5'd0, border_q};
         default:     port_in = PORT_UNMAPPED;
      endcase
   end

   assign irq     = irq_q;
   assign irq_vec = irq_vec_q;
   assign border  = border_q;

endmodule
